cnn_mul_share_arbiter: RTL and testbench
========================================

// Module: cnn_mul_share_arbiter
// PURPOSE
//  Time-shares one signed-14b x unsigned-7b multiplier (21b signed product) between NUM_REQ conv1 requesters.
//  Per-requester valid/ready inputs; round-robin grant; pipelined multiply; tagged results into an output FIFO with ready backpressure.
//  Sits between the conv1 pixel/weight fetch lanes and the per-channel accumulators; replaces one DSP48 per lane.
// PARAMETERS
//  NUM_REQ     4  number of requesters (2..8)
//  MUL_STAGES  2  multiplier pipeline registers (1..4)
//  OUT_DEPTH   4  result FIFO depth, power of 2, >= MUL_STAGES+1
//  ID_W        2  tag width, = clog2(NUM_REQ)
// PORTS
//  ap_clk     in   1              clock, rising edge
//  ap_rst_n   in   1              asynchronous active-low reset
//  req_valid  in   NUM_REQ        request i valid
//  req_a      in   14*NUM_REQ     signed operand, lane i at [14*i+:14]
//  req_b      in   7*NUM_REQ      unsigned operand, lane i at [7*i+:7]
//  req_ready  out  NUM_REQ        one-hot grant; transfer when valid&ready
//  res_valid  out  1              FIFO head valid
//  res_data   out  21             signed product a*{1'b0,b}
//  res_id     out  ID_W           requester index of res_data
//  res_ready  in   1              consumer pops head when valid&ready
//  busy       out  1              any op in flight or FIFO non-empty
// BEHAVIOUR
//  Reset (async assert, sync deassert at ap_clk): rr_ptr=0, credits=OUT_DEPTH, pipe valids=0, FIFO empty;
//   res_valid=0, res_data=0, res_id=0, busy=0; req_ready=0 while ap_rst_n low.
//  Reset mid-operation: in-flight ops and FIFO contents discarded, no result emitted for them.
//  Credit: credits = OUT_DEPTH - (in-flight + FIFO occupancy). Issue only when credits>0.
//   issue&pop same cycle: unchanged; issue only: -1; pop only: +1. Never <0 or >OUT_DEPTH.
//  Arbiter: combinational; search req_valid from rr_ptr upward (mod NUM_REQ); first set bit granted
//   if credits>0; at most one req_ready bit high; req_ready=0 for all lanes when credits==0.
//  rr_ptr <= (granted idx + 1) mod NUM_REQ on transfer; unchanged otherwise. Lone requester may issue every cycle.
//  Requesters must hold a/b/valid until ready (AXI-style); arbiter must not depend on ready->valid paths.
//  Datapath: p = $signed(a) * $signed({1'b0,b}), full 21b, no truncation/saturation (range -1040384..1040257).
//  Latency: transfer in cycle T -> entry written into FIFO at end of T+MUL_STAGES; res_valid high from
//   cycle T+MUL_STAGES+1 if FIFO was empty. FIFO show-ahead; order = issue order.
//  FIFO full: impossible via credits; write-when-full is an assertion failure. Pointers wrap mod OUT_DEPTH.
//  Pop & write same cycle with FIFO empty: no bypass; new entry appears next cycle.
//  res_ready low: head and res_data/res_id held stable; issue continues until credits==0.
//  busy = |pipe_valid | fifo non-empty; registered-equivalent, no glitches on reset.
// CONFIGURATION
//  CNN_MUL_ARB_PERF_EN defined: adds outputs perf_issue[31:0] (transfers), perf_stall[31:0]
//   (cycles with |req_valid & credits==0), perf_clr in 1 (sync clear, priority over increment);
//   counters saturate at 32'hFFFF_FFFF, reset to 0.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Lane0 a=-8192,b=127 once, res_ready=1 -> res_data=-1040384, res_id=0, res_valid in cycle T+3 (defaults).
//  2 Lanes 0..3 all valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; products match per id.
//  3 res_ready=0, lane1 streams a=8191,b=127 -> exactly 4 transfers then req_ready=0; release -> 4 results 1040257, no loss.
//  4 Lane2 a=-1,b=0 and a=0,b=127 -> res_data=0 both; a=-1,b=1 -> -1 (sign of b-extension checked).
//  5 ap_rst_n pulsed low with 2 in flight + 2 in FIFO -> res_valid=0, busy=0 immediately; next result only from new issues.
//  6 PERF_EN: 10 transfers, 5 stall cycles -> perf_issue=10, perf_stall=5; perf_clr -> both 0 next cycle.

Source files
------------

// File: rtl/cnn_mul_share_arbiter.sv
// cnn_mul_share_arbiter: round-robin sharing of one signed 14b x unsigned 7b multiplier among NUM_REQ lanes
// Ports:
//   ap_clk, ap_rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_a/req_b       per-lane request; lane i operands at req_a[14*i+:14], req_b[7*i+:7]
//   req_ready                   one-hot grant; a transfer happens on valid & ready
//   res_valid/res_data/res_id   show-ahead result FIFO head: 21b signed product and requester index
//   res_ready                   consumer pops the head on valid & ready
//   busy                        any multiply in flight or FIFO non-empty
// Optional: define CNN_MUL_ARB_PERF_EN to add perf_clr, perf_issue and perf_stall counters.
module cnn_mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MUL_STAGES = 2,
  parameter int OUT_DEPTH  = 4,
  parameter int ID_W       = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [14*NUM_REQ-1:0]     req_a,
  input  logic [7*NUM_REQ-1:0]      req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  output logic signed [20:0]        res_data,
  output logic [ID_W-1:0]           res_id,
  input  logic                      res_ready,
  output logic                      busy
`ifdef CNN_MUL_ARB_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [31:0]               perf_issue,
  output logic [31:0]               perf_stall
`endif
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  logic [ID_W-1:0] rr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0] cr, cnt;
  logic [PW-1:0] wp, rp;
  logic issue, pop, wr;
  logic signed [20:0] prod;
  logic [MUL_STAGES-1:0] pv;
  logic signed [20:0] pd [MUL_STAGES];
  logic [ID_W-1:0] pid [MUL_STAGES];
  logic signed [20:0] fd [OUT_DEPTH];
  logic [ID_W-1:0] fi [OUT_DEPTH];
  // Scan downward so the last hit, i.e. the nearest valid lane at or after rr, wins.
  always_comb begin
    gidx = rr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr) + k) % NUM_REQ]) gidx = ID_W'((int'(rr) + k) % NUM_REQ);
    gnt = (ap_rst_n && cr != '0 && |req_valid) ? NUM_REQ'(1) << gidx : '0;
  end
  assign req_ready = gnt;
  assign issue     = |gnt;
  assign pop       = res_valid & res_ready;
  assign wr        = pv[MUL_STAGES-1];
  assign prod      = 21'($signed(req_a[14*gidx +: 14])) * 21'($signed({1'b0, req_b[7*gidx +: 7]}));
  assign res_valid = cnt != '0;
  assign res_data  = res_valid ? fd[rp] : '0;
  assign res_id    = res_valid ? fi[rp] : '0;
  assign busy      = |pv || cnt != '0;
  // Credits count free FIFO slots not yet promised to an in-flight multiply, so the FIFO never overflows.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr  <= '0;
      cr  <= CW'(OUT_DEPTH);
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
      pv  <= '0;
    end else begin
      if (issue) rr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      cr  <= cr - CW'(issue) + CW'(pop);
      cnt <= cnt + CW'(wr) - CW'(pop);
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      pv  <= MUL_STAGES'({pv, issue});
    end
  end
  // Datapath carries no reset; only the valid bits and FIFO count qualify it.
  always_ff @(posedge ap_clk) begin
    pd[0]  <= prod;
    pid[0] <= gidx;
    for (int s = 1; s < MUL_STAGES; s++) begin
      pd[s]  <= pd[s-1];
      pid[s] <= pid[s-1];
    end
    if (wr) begin
      fd[wp] <= pd[MUL_STAGES-1];
      fi[wp] <= pid[MUL_STAGES-1];
    end
  end
  a_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(wr && !pop && cnt == CW'(OUT_DEPTH)));
`ifdef CNN_MUL_ARB_PERF_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue && perf_issue != '1) perf_issue <= perf_issue + 1'b1;
      if (|req_valid && cr == '0 && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cnn_mul_share_arbiter.sv
// tb_cnn_mul_share_arbiter: table vectors, directed corner sequences and random traffic against a queue model
module tb_cnn_mul_share_arbiter;
  localparam int N = 4, MS = 2, D = 4, IW = 2;
  logic ap_clk = 0, ap_rst_n = 1;
  logic [N-1:0] req_valid = '0;
  logic [14*N-1:0] req_a = '0;
  logic [7*N-1:0] req_b = '0;
  logic res_ready = 0;
  logic [N-1:0] req_ready;
  logic res_valid, busy;
  logic signed [20:0] res_data;
  logic [IW-1:0] res_id;
`ifdef CNN_MUL_ARB_PERF_EN
  logic perf_clr = 0;
  logic [31:0] perf_issue, perf_stall;
`endif

  cnn_mul_share_arbiter #(.NUM_REQ(N), .MUL_STAGES(MS), .OUT_DEPTH(D), .ID_W(IW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
`ifdef CNN_MUL_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
  );

  always #5 ap_clk = ~ap_clk;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic int lane_a(input int j);
    return int'($signed(req_a[14*j +: 14]));
  endfunction
  function automatic int lane_b(input int j);
    return int'(req_b[7*j +: 7]);
  endfunction

  // Reference model: outstanding results in issue order, each with the first cycle it may be visible.
  typedef struct { int id; int data; int rdy; } exp_t;
  exp_t q[$];
  int m_rr = 0;
  bit mon_en = 0;
  logic [N-1:0] eg;
  bit found, ev;
  always @(negedge ap_clk) if (mon_en) begin
    if (!ap_rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 0);
      q.delete();
      m_rr = 0;
    end else begin
      chk("busy", busy, q.size() != 0);
      eg = '0;
      found = 0;
      if (q.size() < D)
        for (int k = 0; k < N; k++)
          if (!found && req_valid[(m_rr + k) % N]) begin
            eg[(m_rr + k) % N] = 1'b1;
            found = 1;
          end
      chk("grant", req_ready, eg);
      ev = q.size() > 0 && q[0].rdy <= cyc;
      chk("res_valid", res_valid, ev);
      if (ev) begin
        chk("res_data", res_data, q[0].data);
        chk("res_id", res_id, q[0].id);
        if (res_ready) void'(q.pop_front());
      end
      for (int j = 0; j < N; j++)
        if (req_valid[j] && req_ready[j]) begin
          q.push_back('{j, lane_a(j) * lane_b(j), cyc + MS + 1});
          m_rr = (j + 1) % N;
        end
    end
  end

  task automatic do_reset();
    req_valid = '0;
    ap_rst_n = 0;
    step();
    step();
    ap_rst_n = 1;
  endtask

  task automatic set_lane(input int l, input int a, input int b);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    req_a[14*l +: 14] = av[13:0];
    req_b[7*l +: 7] = bv[6:0];
  endtask

  task automatic send(input int l, input int a, input int b, output int t);
    set_lane(l, a, b);
    req_valid[l] = 1'b1;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      #1;
      if (req_ready[l]) t = cyc;
      step();
    end
    if (t < 0) chk("send_timeout", 0, 1);
    req_valid[l] = 1'b0;
  endtask

  typedef struct { int lane; int a; int b; int exp; } vec_t;
  vec_t tbl[8];
  int t0, tr, n;
  logic [N-1:0] acc;

  initial begin
    tbl[0] = '{0, -8192, 127, -1040384};
    tbl[1] = '{1, 8191, 127, 1040257};
    tbl[2] = '{2, -1, 0, 0};
    tbl[3] = '{2, 0, 127, 0};
    tbl[4] = '{2, -1, 1, -1};
    tbl[5] = '{3, 100, 3, 300};
    tbl[6] = '{1, -5, 100, -500};
    tbl[7] = '{3, -8192, 1, -8192};
    #1;
    ap_rst_n = 0;
    mon_en = 1;
    step();
    step();
    ap_rst_n = 1;
    res_ready = 1;
    foreach (tbl[i]) begin
      send(tbl[i].lane, tbl[i].a, tbl[i].b, t0);
      tr = -1;
      for (int k = 0; k < 20 && tr < 0; k++) if (res_valid) tr = cyc; else step();
      chk("vec_latency", tr - t0, MS + 1);
      chk("vec_data", res_data, tbl[i].exp);
      chk("vec_id", res_id, tbl[i].lane);
      step();
    end
    // all lanes valid: strict rotation from lane 0
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, i * 1000 - 1700, 10 + i * 30);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_order", req_ready, 1 << (k % N));
      step();
    end
    req_valid = '0;
    repeat (8) step();
    // backpressure: credits stop issue at OUT_DEPTH, nothing lost on release
    do_reset();
    res_ready = 0;
    set_lane(1, 8191, 127);
    req_valid[1] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_ready[1]) n++;
      step();
    end
    chk("stall_xfers", n, D);
    chk("stall_ready", req_ready, 0);
    req_valid = '0;
    res_ready = 1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (res_valid && res_data == 21'sd1040257) n++;
      step();
    end
    chk("stall_drain", n, D);
    // reset with two in flight and two in the FIFO
    do_reset();
    res_ready = 0;
    set_lane(0, 5, 5);
    req_valid[0] = 1'b1;
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", res_valid, 1);
    ap_rst_n = 0;
    req_valid = '0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    ap_rst_n = 1;
    res_ready = 1;
    send(0, -3, 7, t0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (res_valid) begin
        n++;
        chk("post_rst_data", res_data, -21);
      end
      step();
    end
    chk("post_rst_count", n, 1);
`ifdef CNN_MUL_ARB_PERF_EN
    do_reset();
    res_ready = 0;
    set_lane(0, 1, 1);
    req_valid[0] = 1'b1;
    repeat (9) step();
    req_valid = '0;
    res_ready = 1;
    repeat (8) step();
    req_valid[0] = 1'b1;
    repeat (6) step();
    req_valid = '0;
    step();
    chk("perf_issue", perf_issue, 10);
    chk("perf_stall", perf_stall, 5);
    perf_clr = 1;
    step();
    perf_clr = 0;
    chk("perf_issue_clr", perf_issue, 0);
    chk("perf_stall_clr", perf_stall, 0);
`endif
    // random traffic with valid held until accepted
    do_reset();
    acc = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 5))
            0: set_lane(i, -8192, int'($urandom_range(0, 127)));
            1: set_lane(i, 8191, 127);
            default: set_lane(i, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 127)));
          endcase
        end
      res_ready = $urandom_range(0, 3) != 0;
      #1;
      acc = req_valid & req_ready;
      step();
    end
    req_valid = '0;
    res_ready = 1;
    repeat (20) step();
    chk("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
